a2d_spi_resp: RTL and testbench

SPI responder (slave) model of the 8-channel, 12-bit slide-pot ADC, i.e. the far end of the A2D SPI link that the equalizer's A2D interface masters. It oversamples `SS_n`, `SCLK` and `MOSI` on the system clock, captures each 16-bit command frame, and returns the conversion result for the channel addressed in the previous frame. It sits in the system-level testbench, and in the FPGA loopback build, in place of the physical ADC. Channel values are loaded through a simple write port.

---
 rtl/a2d_spi_resp_if.sv | 23 ++
 rtl/a2d_spi_resp.sv | 140 ++++++++++++++
 tb/tb_a2d_spi_resp.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/a2d_spi_resp_if.sv
// SPI pin group plus channel-load port and frame status for the ADC responder model.
interface a2d_spi_resp_if;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    logic        MISO;
    logic        wr_en;
    logic [2:0]  wr_chnl;
    logic [11:0] wr_data;
    logic        frame_done;
    logic        frame_err;
    logic [2:0]  last_chnl;

    modport master (
        output SS_n, SCLK, MOSI, wr_en, wr_chnl, wr_data,
        input  MISO, frame_done, frame_err, last_chnl
    );

    modport slave (
        input  SS_n, SCLK, MOSI, wr_en, wr_chnl, wr_data,
        output MISO, frame_done, frame_err, last_chnl
    );
endinterface

// File: rtl/a2d_spi_resp.sv
// SPI responder standing in for the 8-channel 12-bit ADC; returns the channel addressed by the previous frame.
// Pin edge to register update is 3 clk, MISO bit valid 4 clk after its launching pin edge; no backpressure.
module a2d_spi_resp #(
    parameter logic [11:0] RST_VAL = 12'h800
) (
    input  logic           clk,
    input  logic           rst,
    a2d_spi_resp_if.slave  spi
);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t      state, state_nxt;
    logic [2:0]  ss_sync;
    logic [2:0]  sclk_sync;
    logic [1:0]  mosi_sync;
    logic        ss_fall, ss_rise, sclk_rise, sclk_fall;

    logic [11:0] chan [8];
    logic [15:0] rx_shift;
    logic [15:0] tx_shift;
    logic [4:0]  bit_cnt;
    logic [2:0]  ptr_chnl;
    logic [2:0]  last_chnl_q;
    logic        miso_q, frame_done_q, frame_err_q;
    logic [11:0] tx_src;
    logic        rx_unused;

    logic        load_tx, shift_rx, shift_tx, done_nxt, err_nxt;

    // SS_n chain resets low so a select already held low at reset release is not a frame start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ss_sync   <= 3'b000;
            sclk_sync <= 3'b000;
            mosi_sync <= 2'b00;
        end else begin
            ss_sync   <= {ss_sync[1:0], spi.SS_n};
            sclk_sync <= {sclk_sync[1:0], spi.SCLK};
            mosi_sync <= {mosi_sync[0], spi.MOSI};
        end
    end

    assign ss_fall   = ~ss_sync[1] &  ss_sync[2];
    assign ss_rise   =  ss_sync[1] & ~ss_sync[2];
    assign sclk_rise =  sclk_sync[1] & ~sclk_sync[2];
    assign sclk_fall = ~sclk_sync[1] &  sclk_sync[2];

    // A write to the channel being loaded in the same cycle is forwarded into the frame
    assign tx_src = (spi.wr_en && spi.wr_chnl == ptr_chnl) ? spi.wr_data : chan[ptr_chnl];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load_tx   = 1'b0;
        shift_rx  = 1'b0;
        shift_tx  = 1'b0;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (ss_fall) begin
                    load_tx   = 1'b1;
                    state_nxt = ACTIVE;
                end
            end
            ACTIVE: begin
                shift_rx = sclk_rise;
                shift_tx = sclk_fall && (bit_cnt >= 5'd1) && (bit_cnt <= 5'd15);
                if (ss_rise) begin
                    state_nxt = IDLE;
                    done_nxt  = (bit_cnt == 5'd16);
                    err_nxt   = (bit_cnt != 5'd16);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_shift     <= 16'h0000;
            tx_shift     <= 16'h0000;
            bit_cnt      <= 5'd0;
            ptr_chnl     <= 3'd0;
            last_chnl_q  <= 3'd0;
            miso_q       <= 1'b0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            if (load_tx) begin
                tx_shift <= {4'h0, tx_src};
                bit_cnt  <= 5'd0;
            end else begin
                if (shift_tx) begin
                    tx_shift <= {tx_shift[14:0], 1'b0};
                end
                if (shift_rx) begin
                    rx_shift <= {rx_shift[14:0], mosi_sync[1]};
                    if (bit_cnt != 5'd17) begin
                        bit_cnt <= bit_cnt + 5'd1;
                    end
                end
            end
            if (done_nxt) begin
                ptr_chnl    <= rx_shift[13:11];
                last_chnl_q <= rx_shift[13:11];
            end
            frame_done_q <= done_nxt;
            frame_err_q  <= err_nxt;
            miso_q       <= (state == ACTIVE) ? tx_shift[15] : 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                chan[i] <= RST_VAL;
            end
        end else if (spi.wr_en) begin
            chan[spi.wr_chnl] <= spi.wr_data;
        end
    end

    // Command bit 15 carries no channel information
    assign rx_unused = rx_shift[15];

    assign spi.MISO       = miso_q;
    assign spi.frame_done = frame_done_q;
    assign spi.frame_err  = frame_err_q;
    assign spi.last_chnl  = last_chnl_q;

endmodule

// File: tb/tb_a2d_spi_resp.sv
// Directed bench for the ADC SPI responder: pipelined reads, bad frame lengths, write timing, resets.
module tb_a2d_spi_resp;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    a2d_spi_resp_if bus();

    a2d_spi_resp #(.RST_VAL(12'h800)) dut (
        .clk (clk),
        .rst (rst),
        .spi (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [15:0] mw;
    int dn, er, pp;

    task automatic tick(input int wr_at, input logic [2:0] wch, input logic [11:0] wval, inout int cyc);
        @(negedge clk);
        cyc++;
        if (cyc == wr_at) begin
            bus.wr_en   = 1'b1;
            bus.wr_chnl = wch;
            bus.wr_data = wval;
        end else begin
            bus.wr_en = 1'b0;
        end
    endtask

    // Full master transaction: 8 clk setup, nclk SCLK periods of 16 clk, then 10 clk watching for pulses
    task automatic do_frame(input logic [15:0] cmd, input int nclk, input int wr_at,
                            input logic [2:0] wch, input logic [11:0] wval,
                            output logic [15:0] miso_w, output int ndone, output int nerr, output int ppos);
        int cyc;
        cyc    = 0;
        miso_w = 16'h0000;
        ndone  = 0;
        nerr   = 0;
        ppos   = -1;
        @(negedge clk);
        bus.SS_n = 1'b0;
        bus.MOSI = cmd[15];
        repeat (8) tick(wr_at, wch, wval, cyc);
        for (int i = 0; i < nclk; i++) begin
            if (i < 16) miso_w = {miso_w[14:0], bus.MISO};
            bus.SCLK = 1'b1;
            repeat (8) tick(wr_at, wch, wval, cyc);
            bus.SCLK = 1'b0;
            bus.MOSI = (i < 15) ? cmd[14-i] : 1'b0;
            repeat (8) tick(wr_at, wch, wval, cyc);
        end
        bus.SS_n  = 1'b1;
        bus.wr_en = 1'b0;
        for (int j = 1; j <= 10; j++) begin
            @(negedge clk);
            if (bus.frame_done === 1'b1) begin
                ndone++;
                if (ppos < 0) ppos = j;
            end
            if (bus.frame_err === 1'b1) begin
                nerr++;
                if (ppos < 0) ppos = j;
            end
        end
    endtask

    task automatic write_chnl(input logic [2:0] ch, input logic [11:0] val);
        @(negedge clk);
        bus.wr_en   = 1'b1;
        bus.wr_chnl = ch;
        bus.wr_data = val;
        @(negedge clk);
        bus.wr_en   = 1'b0;
    endtask

    task automatic test_reset;
        rst         = 1'b1;
        bus.SS_n    = 1'b1;
        bus.SCLK    = 1'b0;
        bus.MOSI    = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_chnl = 3'd0;
        bus.wr_data = 12'h000;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.MISO !== 1'b0) begin errors++; $display("FAIL reset_miso: got %b want 0", bus.MISO); end
        checks++;
        if (bus.frame_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.frame_done); end
        checks++;
        if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", bus.frame_err); end
        checks++;
        if (bus.last_chnl !== 3'd0) begin errors++; $display("FAIL reset_last_chnl: got %0d want 0", bus.last_chnl); end
        rst = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_basic;
        do_frame(16'h0000, 16, -1, 3'd0, 12'h000, mw, dn, er, pp);
        checks++;
        if (mw !== 16'h0800) begin errors++; $display("FAIL basic_miso: got %h want 0800", mw); end
        checks++;
        if (dn !== 1 || er !== 0) begin errors++; $display("FAIL basic_pulses: got done=%0d err=%0d want 1/0", dn, er); end
        checks++;
        if (pp !== 3) begin errors++; $display("FAIL basic_pulse_latency: got %0d want 3", pp); end
        checks++;
        if (bus.last_chnl !== 3'd0) begin errors++; $display("FAIL basic_last_chnl: got %0d want 0", bus.last_chnl); end
    endtask

    task automatic test_pipelined_read;
        write_chnl(3'd5, 12'hABC);
        do_frame(16'h2800, 16, -1, 3'd0, 12'h000, mw, dn, er, pp);
        checks++;
        if (mw !== 16'h0800) begin errors++; $display("FAIL pipe1_miso: got %h want 0800", mw); end
        checks++;
        if (bus.last_chnl !== 3'd5 || dn !== 1) begin errors++; $display("FAIL pipe1_last: got ch=%0d done=%0d want 5/1", bus.last_chnl, dn); end
        do_frame(16'h0000, 16, -1, 3'd0, 12'h000, mw, dn, er, pp);
        checks++;
        if (mw !== 16'h0ABC) begin errors++; $display("FAIL pipe2_miso: got %h want 0abc", mw); end
        checks++;
        if (bus.last_chnl !== 3'd0) begin errors++; $display("FAIL pipe2_last: got %0d want 0", bus.last_chnl); end
    endtask

    task automatic test_bad_length;
        write_chnl(3'd6, 12'h666);
        write_chnl(3'd3, 12'h333);
        do_frame(16'h3000, 16, -1, 3'd0, 12'h000, mw, dn, er, pp);
        checks++;
        if (bus.last_chnl !== 3'd6) begin errors++; $display("FAIL bad_setup_last: got %0d want 6", bus.last_chnl); end
        do_frame(16'h1800, 8, -1, 3'd0, 12'h000, mw, dn, er, pp);
        checks++;
        if (er !== 1 || dn !== 0) begin errors++; $display("FAIL short_pulses: got done=%0d err=%0d want 0/1", dn, er); end
        checks++;
        if (bus.last_chnl !== 3'd6) begin errors++; $display("FAIL short_last: got %0d want 6", bus.last_chnl); end
        do_frame(16'h3000, 16, -1, 3'd0, 12'h000, mw, dn, er, pp);
        checks++;
        if (mw !== 16'h0666) begin errors++; $display("FAIL after_short_miso: got %h want 0666", mw); end
        do_frame(16'h1800, 17, -1, 3'd0, 12'h000, mw, dn, er, pp);
        checks++;
        if (er !== 1 || dn !== 0) begin errors++; $display("FAIL long_pulses: got done=%0d err=%0d want 0/1", dn, er); end
        checks++;
        if (bus.last_chnl !== 3'd6) begin errors++; $display("FAIL long_last: got %0d want 6", bus.last_chnl); end
        do_frame(16'h2800, 16, -1, 3'd0, 12'h000, mw, dn, er, pp);
        checks++;
        if (mw !== 16'h0666) begin errors++; $display("FAIL after_long_miso: got %h want 0666", mw); end
    endtask

    task automatic test_write_timing;
        do_frame(16'h2800, 16, 40, 3'd5, 12'h123, mw, dn, er, pp);
        checks++;
        if (mw !== 16'h0ABC) begin errors++; $display("FAIL midwrite_cur_miso: got %h want 0abc", mw); end
        do_frame(16'h2800, 16, -1, 3'd0, 12'h000, mw, dn, er, pp);
        checks++;
        if (mw !== 16'h0123) begin errors++; $display("FAIL midwrite_next_miso: got %h want 0123", mw); end
        // cycle 2 after the SS_n fall is the edge on which tx_shift loads
        do_frame(16'h2800, 16, 2, 3'd5, 12'h456, mw, dn, er, pp);
        checks++;
        if (mw !== 16'h0456) begin errors++; $display("FAIL writethrough_miso: got %h want 0456", mw); end
        checks++;
        if (bus.last_chnl !== 3'd5) begin errors++; $display("FAIL writethrough_last: got %0d want 5", bus.last_chnl); end
    endtask

    task automatic test_idle_sclk;
        int bad;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            bus.SCLK = 1'b1;
            bus.MOSI = ~bus.MOSI;
            repeat (8) begin
                @(negedge clk);
                if (bus.MISO !== 1'b0 || bus.frame_done !== 1'b0 || bus.frame_err !== 1'b0) bad++;
            end
            bus.SCLK = 1'b0;
            repeat (8) begin
                @(negedge clk);
                if (bus.MISO !== 1'b0 || bus.frame_done !== 1'b0 || bus.frame_err !== 1'b0) bad++;
            end
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL idle_sclk_quiet: got %0d bad cycles want 0", bad); end
        do_frame(16'h0000, 16, -1, 3'd0, 12'h000, mw, dn, er, pp);
        checks++;
        if (mw !== 16'h0456 || dn !== 1) begin errors++; $display("FAIL idle_sclk_next: got %h done=%0d want 0456/1", mw, dn); end
    endtask

    task automatic test_reset_midframe;
        int bad;
        write_chnl(3'd2, 12'hFFF);
        do_frame(16'h1000, 16, -1, 3'd0, 12'h000, mw, dn, er, pp);
        checks++;
        if (mw !== 16'h0800 || bus.last_chnl !== 3'd2) begin errors++; $display("FAIL rstmid_setup: got %h ch=%0d want 0800/2", mw, bus.last_chnl); end
        @(negedge clk);
        bus.SS_n = 1'b0;
        bus.MOSI = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 7; i++) begin
            bus.SCLK = 1'b1;
            repeat (8) @(negedge clk);
            bus.SCLK = 1'b0;
            repeat (8) @(negedge clk);
        end
        checks++;
        if (bus.MISO !== 1'b1) begin errors++; $display("FAIL rstmid_pre_miso: got %b want 1", bus.MISO); end
        rst = 1'b1;
        #1;
        checks++;
        if (bus.MISO !== 1'b0) begin errors++; $display("FAIL rstmid_miso: got %b want 0", bus.MISO); end
        checks++;
        if (bus.last_chnl !== 3'd0) begin errors++; $display("FAIL rstmid_last: got %0d want 0", bus.last_chnl); end
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.frame_done !== 1'b0 || bus.frame_err !== 1'b0) bad++;
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.SCLK = 1'b1;
            repeat (8) begin
                @(negedge clk);
                if (bus.MISO !== 1'b0 || bus.frame_done !== 1'b0 || bus.frame_err !== 1'b0) bad++;
            end
            bus.SCLK = 1'b0;
            repeat (8) begin
                @(negedge clk);
                if (bus.MISO !== 1'b0 || bus.frame_done !== 1'b0 || bus.frame_err !== 1'b0) bad++;
            end
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL rstmid_quiet: got %0d bad cycles want 0", bad); end
        bus.SS_n = 1'b1;
        repeat (10) @(negedge clk);
        do_frame(16'h0000, 16, -1, 3'd0, 12'h000, mw, dn, er, pp);
        checks++;
        if (mw !== 16'h0800) begin errors++; $display("FAIL rstmid_after_miso: got %h want 0800", mw); end
        checks++;
        if (dn !== 1 || er !== 0) begin errors++; $display("FAIL rstmid_after_pulses: got done=%0d err=%0d want 1/0", dn, er); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_pipelined_read();
        test_bad_length();
        test_write_timing();
        test_idle_sclk();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
